// File: rtl/nibble_serial_alu_ctrl_pkg.sv
// Shared op codes, state codes and flag helpers for the nibble-serial ALU sequencer.
package nibble_serial_alu_ctrl_pkg;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_ADDNB = 2'b01;
    localparam logic [1:0] OP_PASS  = 2'b10;
    localparam logic [1:0] OP_DEC   = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_EXEC = 2'b01;
    localparam logic [1:0] ST_RESP = 2'b10;

    // Sign bit of the second adder operand Y as the ALU select shapes it.
    function automatic logic y_msb(input logic [1:0] op, input logic b_msb);
        case (op)
            OP_ADD:   y_msb = b_msb;
            OP_ADDNB: y_msb = ~b_msb;
            OP_PASS:  y_msb = 1'b0;
            default:  y_msb = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/nibble_serial_alu_ctrl_settle_timer.sv
// Settle counter: counts held clocks per nibble and flags the capture clock.
module nibble_serial_alu_ctrl_settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam int CW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

    logic [CW-1:0] cnt;

    assign done = (cnt == CW'(SETTLE_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= done ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/nibble_serial_alu_ctrl.sv
// Runs wide add/sub/pass/decrement on an external 4-bit ALU one nibble at a time,
// chaining the carry and holding each nibble for a settle window before capture.
module nibble_serial_alu_ctrl
    import nibble_serial_alu_ctrl_pkg::*;
#(
    parameter int NIBBLES       = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic                 req_cin,
    input  logic [4*NIBBLES-1:0] req_a,
    input  logic [4*NIBBLES-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [4*NIBBLES-1:0] rsp_d,
    output logic                 rsp_cout,
    output logic                 rsp_zero,
    output logic                 rsp_ovf,
    output logic [15:0]          ops_done,
    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    output logic [1:0]           alu_s,
    output logic                 alu_cin,
    input  logic [3:0]           alu_d,
    input  logic                 alu_cout
);

    localparam int IW = (NIBBLES < 2) ? 1 : $clog2(NIBBLES);

    logic [1:0]              state;
    logic [NIBBLES-1:0][3:0] a_reg;
    logic [NIBBLES-1:0][3:0] b_reg;
    logic [NIBBLES-1:0][3:0] res_work;
    logic [NIBBLES-1:0][3:0] res_next;
    logic [1:0]              op_reg;
    logic                    carry_reg;
    logic [IW-1:0]           idx;
    logic                    accept;
    logic                    exec_active;
    logic                    settle_done;
    logic                    capture;
    logic                    last_nibble;
    logic                    ovf_next;

    assign accept      = (state == ST_IDLE) && req_ready && req_valid;
    assign exec_active = (state == ST_EXEC);
    assign capture     = exec_active && settle_done;
    assign last_nibble = (idx == IW'(NIBBLES - 1));

    nibble_serial_alu_ctrl_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept),
        .enable(exec_active),
        .done  (settle_done)
    );

    // ALU drive is a mux of registered state only, so nothing from req_* or alu_d loops back.
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_s   = '0;
        alu_cin = 1'b0;
        if (exec_active) begin
            alu_a   = a_reg[idx];
            alu_b   = b_reg[idx];
            alu_s   = op_reg;
            alu_cin = carry_reg;
        end
    end

    always_comb begin
        res_next      = res_work;
        res_next[idx] = alu_d;
    end

    assign ovf_next = (a_reg[NIBBLES-1][3] == y_msb(op_reg, b_reg[NIBBLES-1][3])) &&
                      (res_next[NIBBLES-1][3] != a_reg[NIBBLES-1][3]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            req_ready <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            res_work  <= '0;
            op_reg    <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            rsp_valid <= 1'b0;
            rsp_d     <= '0;
            rsp_cout  <= 1'b0;
            rsp_zero  <= 1'b0;
            rsp_ovf   <= 1'b0;
            ops_done  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        a_reg     <= req_a;
                        b_reg     <= req_b;
                        op_reg    <= req_op;
                        carry_reg <= req_cin;
                        idx       <= '0;
                        req_ready <= 1'b0;
                        state     <= ST_EXEC;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (capture) begin
                        res_work[idx] <= alu_d;
                        carry_reg     <= alu_cout;
                        if (last_nibble) begin
                            rsp_d     <= res_next;
                            rsp_cout  <= alu_cout;
                            rsp_zero  <= (res_next == '0);
                            rsp_ovf   <= ovf_next;
                            rsp_valid <= 1'b1;
                            state     <= ST_RESP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        ops_done  <= ops_done + 16'd1;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Self-checking bench: directed vector table, hand sequences for stall/reset, and
// randomized ops against a plain-arithmetic reference model with a delayed 4-bit ALU.
module tb_nibble_serial_alu_ctrl;

    localparam int NIB = 4;
    localparam int SET = 2;
    localparam int LAT = NIB * (SET + 1);

    typedef struct {
        logic [1:0]  op;
        logic        cin;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] d;
        logic        cout;
        logic        zero;
        logic        ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic        req_cin = 1'b0;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_d;
    logic        rsp_cout;
    logic        rsp_zero;
    logic        rsp_ovf;
    logic [15:0] ops_done;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [1:0]  alu_s;
    logic        alu_cin;
    logic [3:0]  alu_d;
    logic        alu_cout;

    int pass_cnt = 0;
    int check_cnt = 0;
    int exp_ops = 0;

    always #5 clk = ~clk;

    nibble_serial_alu_ctrl #(.NIBBLES(NIB), .SETTLE_CYCLES(SET)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_cin(req_cin),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_d(rsp_d), .rsp_cout(rsp_cout),
        .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .ops_done(ops_done),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_cin(alu_cin),
        .alu_d(alu_d), .alu_cout(alu_cout)
    );

    // Gate-delay ALU stand-in: output settles 3 ns after any input change.
    logic [4:0] alu_now;
    logic [4:0] alu_res = '0;
    logic [3:0] alu_y;
    always_comb begin
        alu_y = 4'h0;
        case (alu_s)
            2'b00:   alu_y = alu_b;
            2'b01:   alu_y = ~alu_b;
            2'b10:   alu_y = 4'h0;
            default: alu_y = 4'hF;
        endcase
        alu_now = {1'b0, alu_a} + {1'b0, alu_y} + {4'b0, alu_cin};
    end
    always @(alu_now) alu_res <= #3 alu_now;
    assign alu_d    = alu_res[3:0];
    assign alu_cout = alu_res[4];

    function automatic logic [15:0] y_of(input logic [1:0] op, input logic [15:0] b);
        case (op)
            2'b00:   y_of = b;
            2'b01:   y_of = ~b;
            2'b10:   y_of = 16'h0000;
            default: y_of = 16'hFFFF;
        endcase
    endfunction

    function automatic vec_t model(input logic [1:0] op, input logic cin,
                                   input logic [15:0] a, input logic [15:0] b);
        vec_t r;
        int unsigned s;
        logic [15:0] y;
        y = y_of(op, b);
        s = int'(a) + int'(y) + int'(cin);
        r.op = op; r.cin = cin; r.a = a; r.b = b;
        r.d    = s[15:0];
        r.cout = s[16];
        r.zero = (s[15:0] == 16'h0);
        r.ovf  = (a[15] == y[15]) && (s[15] != a[15]);
        return r;
    endfunction

    // Carry entering each nibble: carry out of the low 4k bits of the full sum.
    function automatic logic [3:0] nibble_carries(input logic [1:0] op, input logic cin,
                                                  input logic [15:0] a, input logic [15:0] b);
        logic [3:0] c;
        int unsigned mask;
        int unsigned s;
        logic [15:0] y;
        y = y_of(op, b);
        for (int k = 0; k < NIB; k++) begin
            mask = (32'd1 << (4 * k)) - 1;
            s = (int'(a) & mask) + (int'(y) & mask) + int'(cin);
            c[k] = (k == 0) ? cin : s[4 * k];
        end
        return c;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    endtask

    // Presents a request and returns #1 after the accept edge.
    task automatic applyStimulus(input logic [1:0] op, input logic cin,
                                 input logic [15:0] a, input logic [15:0] b);
        int waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) checkOutput("req_ready_timeout", 32'(req_ready), 32'd1);
        req_op = op; req_cin = cin; req_a = a; req_b = b; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Starts #1 after the accept edge; checks nibble sequencing, latency and result.
    task automatic await_result(input string tag, input vec_t e);
        logic [3:0]  cin_seq [LAT];
        logic [3:0]  a_seq [LAT];
        logic [3:0]  got_c;
        logic [15:0] got_a;
        int lat = 0;
        cin_seq[0] = {3'b0, alu_cin};
        a_seq[0]   = alu_a;
        for (int j = 1; j <= 100; j++) begin
            @(posedge clk);
            #1;
            if (j < LAT) begin
                cin_seq[j] = {3'b0, alu_cin};
                a_seq[j]   = alu_a;
            end
            if (rsp_valid) begin
                lat = j;
                break;
            end
        end
        for (int k = 0; k < NIB; k++) begin
            got_c[k] = cin_seq[k * (SET + 1)][0];
            got_a[4 * k +: 4] = a_seq[k * (SET + 1)];
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'(LAT));
        checkOutput({tag, "_alu_cin_seq"}, 32'(got_c), 32'(nibble_carries(e.op, e.cin, e.a, e.b)));
        checkOutput({tag, "_alu_a_seq"}, 32'(got_a), 32'(e.a));
        checkOutput({tag, "_rsp"}, {12'b0, rsp_cout, rsp_zero, rsp_ovf, 1'b0, rsp_d},
                    {12'b0, e.cout, e.zero, e.ovf, 1'b0, e.d});
    endtask

    task automatic finish_op(input string tag, input logic early, input logic [15:0] exp_d);
        if (!early) begin
            @(negedge clk);
            rsp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        exp_ops++;
        checkOutput({tag, "_handshake"}, {15'b0, rsp_valid, ops_done}, {15'b0, 1'b0, 16'(exp_ops)});
        checkOutput({tag, "_rsp_d_hold"}, 32'(rsp_d), 32'(exp_d));
    endtask

    vec_t vecs [7];

    initial begin
        vec_t e;
        logic early;
        int bad;

        vecs[0] = '{2'b00, 1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{2'b01, 1'b1, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{2'b01, 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{2'b11, 1'b0, 16'h0000, 16'h1234, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{2'b10, 1'b1, 16'hFFFF, 16'h5A5A, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{2'b00, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{2'b00, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
        checkOutput("reset_rsp", {rsp_valid, rsp_cout, rsp_zero, rsp_ovf, rsp_d}, 20'h0);
        checkOutput("reset_ops_done", 32'(ops_done), 32'd0);
        checkOutput("reset_alu", {alu_a, alu_b, alu_s, alu_cin}, 11'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ready_after_release", 32'(req_ready), 32'd1);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].op, vecs[i].cin, vecs[i].a, vecs[i].b);
            await_result($sformatf("vec%0d", i), vecs[i]);
            finish_op($sformatf("vec%0d", i), 1'b0, vecs[i].d);
        end

        // Overflow on subtract, with consumer already ready when the result appears
        e = model(2'b01, 1'b1, 16'h8000, 16'h0001);
        applyStimulus(e.op, e.cin, e.a, e.b);
        rsp_ready = 1'b1;
        await_result("sub_ovf_early", e);
        finish_op("sub_ovf_early", 1'b1, e.d);

        // Stalled consumer with a pending request
        e = model(2'b00, 1'b0, 16'h1111, 16'h2222);
        applyStimulus(e.op, e.cin, e.a, e.b);
        await_result("stall", e);
        @(negedge clk);
        req_op = 2'b00; req_cin = 1'b1; req_a = 16'hABCD; req_b = 16'h0101; req_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid !== 1'b1 || rsp_d !== e.d || req_ready !== 1'b0 || alu_a !== 4'h0)
                bad++;
        end
        checkOutput("stall_stable_cycles_bad", 32'(bad), 32'd0);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        exp_ops++;
        checkOutput("stall_release", {15'b0, req_ready, ops_done}, {15'b0, 1'b1, 16'(exp_ops)});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("next_accept", {27'b0, req_ready, alu_a}, {27'b0, 1'b0, 4'hD});
        e = model(2'b00, 1'b1, 16'hABCD, 16'h0101);
        await_result("after_stall", e);
        finish_op("after_stall", 1'b0, e.d);

        // Randomized ops against the reference model
        for (int i = 0; i < 24; i++) begin
            e = model(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      16'($urandom), 16'($urandom));
            early = 1'($urandom_range(0, 1));
            applyStimulus(e.op, e.cin, e.a, e.b);
            if (early) rsp_ready = 1'b1;
            await_result($sformatf("rnd%0d", i), e);
            finish_op($sformatf("rnd%0d", i), early, e.d);
        end

        // Reset during nibble 2
        applyStimulus(2'b00, 1'b0, 16'h1234, 16'h1111);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_rsp", {req_ready, rsp_valid, rsp_d, ops_done}, 34'h0);
        checkOutput("midreset_alu", {alu_a, alu_b, alu_s, alu_cin}, 11'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_ops = 0;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid !== 1'b0) bad++;
        end
        checkOutput("no_rsp_after_reset", 32'(bad), 32'd0);
        e = model(2'b00, 1'b0, 16'h0001, 16'h0001);
        applyStimulus(e.op, e.cin, e.a, e.b);
        await_result("post_reset", e);
        finish_op("post_reset", 1'b0, 16'h0002);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/nibble_serial_alu_ctrl.md
Name: nibble_serial_alu_ctrl

Overview:
- Sequencer that runs wide (4*NIBBLES-bit) add, subtract, pass and decrement operations on the existing 4-bit mux+adder ALU datapath, one nibble at a time, chaining the carry between nibbles.
- Gives each nibble a fixed settle window so the gate-delay ALU output is stable before capture.
- Sits between a valid/ready requester and the combinational ALU.
- Produces a registered result with carry, zero and signed-overflow flags.

Parameters:
- NIBBLES, 4: operand width in nibbles (W = 4*NIBBLES); legal range 1 or more.
- SETTLE_CYCLES, 2: extra clocks each nibble is held on the ALU before capture; legal range 0 or more.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_op  in  2  ALU select code: 00 add, 01 A+~B, 10 A+0, 11 A+all-ones.
- req_cin  in  1  carry into nibble 0.
- req_a  in  W  operand A.
- req_b  in  W  operand B; ignored for ops 10 and 11.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_d  out  W  result.
- rsp_cout  out  1  carry out of the top nibble.
- rsp_zero  out  1  rsp_d == 0.
- rsp_ovf  out  1  signed overflow.
- ops_done  out  16  count of completed response handshakes; wraps at 0xFFFF to 0.
- alu_a  out  4  nibble of A driven to the ALU.
- alu_b  out  4  nibble of B driven to the ALU.
- alu_s  out  2  ALU select.
- alu_cin  out  1  ALU carry in.
- alu_d  in  4  ALU sum.
- alu_cout  in  1  ALU carry out.

Behaviour:
- Reset (asynchronous, immediate while rst_n=0):
  - state=IDLE.
  - req_ready=0 while in reset, then 1 from the first clock edge after release.
  - rsp_valid=0, rsp_d=0, rsp_cout=0, rsp_zero=0, rsp_ovf=0, ops_done=0.
  - alu_a=0, alu_b=0, alu_s=00, alu_cin=0; idx=0, cnt=0.
- States IDLE, EXEC, RESP:
  - IDLE: req_ready=1. When req_valid=1 at a posedge, register req_a, req_b, req_op and req_cin (carry reg = req_cin), set idx=0, cnt=0, go to EXEC. req_* are sampled only on this edge.
  - EXEC: req_ready=0.
    - alu_a = A[4*idx+3:4*idx], alu_b = B nibble idx, alu_s = op, alu_cin = carry reg.
    - All alu_* outputs come from registers only; there is no combinational path from req_* or alu_d.
    - Each edge with cnt<SETTLE_CYCLES: cnt++.
    - Edge with cnt==SETTLE_CYCLES: result nibble idx <= alu_d, carry reg <= alu_cout, cnt=0.
    - On that edge, if idx==NIBBLES-1 go to RESP and set the flags; otherwise idx++.
  - RESP: rsp_valid=1; rsp_d and all flags stay stable until handshake. On rsp_ready=1: ops_done++, rsp_valid=0, go to IDLE.
- Latency: rsp_valid rises exactly NIBBLES*(SETTLE_CYCLES+1) clocks after the accept edge (12 at defaults).
- Throughput: after the handshake edge, IDLE accepts on the next edge. rsp_ready may already be high when rsp_valid first rises; the handshake then completes on that edge.
- Arithmetic: result = A + Y + req_cin mod 2^W, where Y is B, ~B, 0 or all-ones for op 00, 01, 10, 11. rsp_cout is the final carry reg.
- Flags:
  - rsp_zero = (result == 0).
  - rsp_ovf = (A[W-1]==Y[W-1]) && (result[W-1]!=A[W-1]), valid for all ops.
  - All flags are registered on the final capture edge.
- Outside EXEC, alu_* are driven to 0.
- Reset mid-operation: operation discarded, no response, ops_done unchanged.
- rsp_d holds its last value after the handshake until the next result is captured.

Decomposition:
- Shared localparam include: op codes OP_ADD=2'b00, OP_ADDNB=2'b01, OP_PASS=2'b10, OP_DEC=2'b11; state codes ST_IDLE, ST_EXEC, ST_RESP.
- One sub-module, settle_timer: cnt register with load/clear and terminal-count output at SETTLE_CYCLES.

Test Plan:
All cases use defaults and a 4-bit ALU model whose delay is below (SETTLE_CYCLES+1) clock periods.
1. OP_ADD a=0x1234 b=0x4321 cin=0 -> rsp_d=0x5555, cout=0, zero=0, ovf=0; rsp_valid exactly 12 clocks after the accept edge.
2. OP_ADDNB cin=1: a=0x0007 b=0x0005 -> 0x0002 cout=1; a=0x0005 b=0x0007 -> 0xFFFE cout=0.
3. OP_DEC cin=0 a=0x0000 -> 0xFFFF cout=0; OP_PASS cin=1 a=0xFFFF -> 0x0000 cout=1 zero=1; OP_ADD 0x7FFF+0x0001 -> 0x8000 ovf=1.
4. OP_ADD a=0xFFFF b=0x0001 -> alu_cin per nibble observed as 0,1,1,1; rsp_d=0x0000, cout=1, zero=1.
5. Hold rsp_ready=0 for 20 clocks with req_valid=1 -> rsp_* stable, req_ready=0, no new accept. Then rsp_ready=1 -> ops_done +1, next request accepted on the following edge.
6. Drop rst_n during nibble 2 -> all outputs 0 immediately, no rsp_valid. After release, OP_ADD 0x0001+0x0001 -> 0x0002, ops_done=1.
